div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 195 +++++++++++++++++++
 tb/tb_div_seq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- sequential 32-bit integer divider (RISC-V M-extension semantics).
//
// One restoring radix-2 quotient bit per cycle, MSB first. Operands are taken
// as magnitudes in PREP. Signs are re-applied in FIX. Divide-by-zero and signed
// overflow produce the architecturally defined results instead of the
// iterated ones.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  request present; accepted when req_valid && req_ready
//   req_ready  high only in IDLE while flush is low
//   op1, op2   dividend / divisor, latched on acceptance
//   funct      00 div, 01 divu, 10 rem, 11 remu, latched on acceptance
//   flush      abandon any operation, return to IDLE on the next edge
//   busy       high in every state except IDLE
//   res_valid  result available (DONE state)
//   res_ready  consumer takes the result
//   res        result, held stable while res_valid is high
//
// Configuration macro
//   DIV_SEQ_EARLY_OUT_EN  when defined, divide-by-zero and signed overflow
//                         skip CALC (3-cycle latency instead of 35).
// -----------------------------------------------------------------------------
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [1:0]       funct,
    input  logic             flush,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res
);

    localparam logic [5:0]       LAST_CNT = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [5:0]       cnt;

    logic [WIDTH-1:0] op1_r;
    logic [WIDTH-1:0] op2_r;
    logic [1:0]       funct_r;
    logic [WIDTH-1:0] quo;      // shifts the dividend out and the quotient in
    logic [WIDTH-1:0] rem;      // partial remainder
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic             qneg;
    logic             rneg;
    logic             dz;
    logic             ovf;

    logic             is_signed;
    logic             is_rem;
    logic             dz_c;
    logic             ovf_c;
    logic             accept;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // Magnitude of a two's-complement value; MIN_NEG maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                             input logic                    sgn);
        logic signed [WIDTH-1:0] n;
        n = -v;
        return (sgn && v[WIDTH-1]) ? $unsigned(n) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        return neg ? $unsigned(-s) : v;
    endfunction

    // Final result selection, special cases first.
    function automatic logic [WIDTH-1:0] pick_result(input logic             f_rem,
                                                     input logic             f_dz,
                                                     input logic             f_ovf,
                                                     input logic [WIDTH-1:0] dividend,
                                                     input logic [WIDTH-1:0] q,
                                                     input logic [WIDTH-1:0] r,
                                                     input logic             q_neg,
                                                     input logic             r_neg);
        if (f_dz)
            return f_rem ? dividend : '1;
        else if (f_ovf)
            return f_rem ? '0 : MIN_NEG;
        else
            return f_rem ? apply_sign(r, r_neg) : apply_sign(q, q_neg);
    endfunction

    assign is_signed = ~funct_r[0];
    assign is_rem    = funct_r[1];
    assign dz_c      = (op2_r == '0);
    assign ovf_c     = is_signed && (op1_r == MIN_NEG) && (op2_r == '1);

    assign req_ready = (state == IDLE) && !flush && !rst;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE);

    // Restoring step: trial-subtract the divisor from the shifted remainder;
    // the top bit of the 34-bit difference is the borrow.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs};

    // Control: state, iteration counter and the registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept)
                        state <= PREP;
                end
                PREP: begin
                    cnt <= '0;
`ifdef DIV_SEQ_EARLY_OUT_EN
                    state <= (dz_c || ovf_c) ? FIX : CALC;
`else
                    state <= CALC;
`endif
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_CNT)
                        state <= FIX;
                end
                FIX: begin
                    res       <= pick_result(is_rem, dz, ovf, op1_r, quo, rem, qneg, rneg);
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand capture, sign preparation and the iteration itself.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    op1_r   <= op1;
                    op2_r   <= op2;
                    funct_r <= funct;
                end
            end
            PREP: begin
                quo  <= mag($signed(op1_r), is_signed);
                dvs  <= mag($signed(op2_r), is_signed);
                rem  <= '0;
                qneg <= is_signed && (op1_r[WIDTH-1] ^ op2_r[WIDTH-1]);
                rneg <= is_signed && op1_r[WIDTH-1];
                dz   <= dz_c;
                ovf  <= ovf_c;
            end
            CALC: begin
                if (!trial[WIDTH+1]) begin
                    rem <= trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq -- scoreboard bench for div_seq.
// Stimulus pushes expected results (directed constants or a plain-arithmetic
// reference model) into a queue; a negedge monitor pops and compares each
// result the DUT presents, including latency measured from the acceptance
// cycle. Honours DIV_SEQ_EARLY_OUT_EN for the special-case latency.
// -----------------------------------------------------------------------------
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [1:0]  funct = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit hold_rr  = 1'b0;

    localparam int LAT_N = 35;
`ifdef DIV_SEQ_EARLY_OUT_EN
    localparam int LAT_S = 3;
`else
    localparam int LAT_S = 35;
`endif

    typedef struct {
        logic [31:0] val;
        int          lat;
    } exp_t;

    exp_t expq[$];
    int   accq[$];

    div_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op1       (op1),
        .op2       (op2),
        .funct     (funct),
        .flush     (flush),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Reference model: architectural division rules with plain arithmetic.
    function automatic void model(input logic [1:0] f, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] v,
                                  output bit special);
        int sa;
        int sb;
        sa = a;
        sb = b;
        special = 1'b0;
        if (b == 0) begin
            special = 1'b1;
            v = f[1] ? a : 32'hFFFF_FFFF;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            special = 1'b1;
            v = f[1] ? 32'h0 : 32'h8000_0000;
        end else begin
            case (f)
                2'b00:   v = 32'(sa / sb);
                2'b01:   v = a / b;
                2'b10:   v = 32'(sa % sb);
                default: v = a % b;
            endcase
        end
    endfunction

    // Consumer side: random back-pressure unless held off.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            res_ready = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    bit          in_done = 1'b0;
    bit          closing = 1'b0;
    logic [31:0] held;
    exp_t        mon_e;
    int          mon_acc;

    always @(negedge clk) begin
        if (rst) begin
            accq.delete();
            in_done = 1'b0;
            closing = 1'b0;
        end else begin
            if (closing) begin
                chk("idle_after_handshake", {31'b0, busy}, 32'h0);
                closing = 1'b0;
            end
            if (req_valid && req_ready)
                accq.push_back(cyc);
            if (flush && busy && !in_done && accq.size() > 0)
                void'(accq.pop_front());
            if (res_valid) begin
                if (!in_done) begin
                    in_done = 1'b1;
                    held = res;
                    if (expq.size() == 0 || accq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result actual=0x%08h required=none", res);
                    end else begin
                        mon_e   = expq.pop_front();
                        mon_acc = accq.pop_front();
                        chk("result", res, mon_e.val);
                        chk("latency", 32'(cyc - mon_acc), 32'(mon_e.lat));
                    end
                end else begin
                    chk("res_stable", res, held);
                end
                if (res_ready || flush) begin
                    closing = 1'b1;
                    in_done = 1'b0;
                end
            end else begin
                in_done = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) fail_timeout("wait_ready");
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((busy || res_valid) && n < 200);
        if (busy || res_valid) fail_timeout("wait_idle");
    endtask

    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] v, input int lat);
        exp_t e;
        wait_ready();
        req_valid = 1'b1;
        funct     = f;
        op1       = a;
        op2       = b;
        if (push) begin
            e.val = v;
            e.lat = lat;
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op1       = $urandom;
        op2       = $urandom;
        funct     = 2'($urandom);
    endtask

    task automatic issue_rand();
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] v;
        bit          sp;
        int          mode;
        f    = 2'($urandom);
        a    = $urandom;
        mode = $urandom_range(0, 9);
        if (mode == 0)      b = 32'h0;
        else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        else if (mode < 5)  b = $urandom_range(1, 255);
        else if (mode < 7)  b = -$urandom_range(1, 255);
        else                b = $urandom;
        model(f, a, b, v, sp);
        issue(f, a, b, 1'b1, v, sp ? LAT_S : LAT_N);
    endtask

    // Directed cases: funct, op1, op2, expected, latency.
    logic [1:0]  df[10] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00};
    logic [31:0] da[10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd64};
    logic [31:0] db[10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2,
                            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] dv[10] = '{32'h0000_000E, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC,
                            32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    int          dl[10] = '{LAT_N, LAT_N, LAT_N, LAT_N, LAT_N, LAT_S, LAT_S, LAT_S, LAT_S, LAT_S};

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("rst_res", res, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);

        // Directed operand table; the first one also sees junk requests while busy.
        for (int i = 0; i < 10; i++) begin
            issue(df[i], da[i], db[i], 1'b1, dv[i], dl[i]);
            if (i == 0) begin
                repeat (3) @(posedge clk);
                #1;
                req_valid = 1'b1;
                op1 = 32'd12345;
                op2 = 32'd1;
                funct = 2'b11;
                repeat (3) @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        end
        wait_idle();

        // flush together with req_valid in IDLE: nothing accepted.
        flush = 1'b1;
        req_valid = 1'b1;
        op1 = 32'd5;
        op2 = 32'd1;
        funct = 2'b00;
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_blocks_accept", {31'b0, busy}, 32'h0);

        // flush at CALC count 10, then a clean follow-up request.
        issue(2'b00, 32'd1000, 32'd3, 1'b0, 32'h0, 0);
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'h0);
        chk("flush_res_valid", {31'b0, res_valid}, 32'h0);
        issue(2'b00, 32'd9, 32'd3, 1'b1, 32'h3, LAT_N);
        wait_idle();

        // Result held while the consumer stalls.
        hold_rr = 1'b1;
        issue(2'b01, 32'd1000, 32'd10, 1'b1, 32'd100, LAT_N);
        begin
            int n = 0;
            while (!res_valid && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (!res_valid) fail_timeout("hold_wait");
        end
        repeat (5) @(posedge clk);
        #1;
        chk("hold_valid", {31'b0, res_valid}, 32'h1);
        hold_rr = 1'b0;
        wait_idle();

        // Randomized traffic against the reference model.
        repeat (40) issue_rand();
        wait_idle();

        // Reset in the middle of CALC.
        issue(2'b00, 32'd77, 32'd5, 1'b0, 32'h0, 0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("midrst_res", res, 32'h0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("postrst_req_ready", {31'b0, req_ready}, 32'h1);
        repeat (40) @(posedge clk);
        issue(2'b10, 32'd100, 32'd7, 1'b1, 32'h2, LAT_N);
        wait_idle();

        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
